// File: rtl/spm_pkg.sv
// Shared definitions for the sparse polynomial multiply accumulator.
//   - trit encodings for the secret coefficient input
//   - FSM state enum
//   - width helpers for the sum (SW) and result (RW) outputs
// Optional feature: SPM_MOD_REDUCE_EN selects mod-Q arithmetic, which
// shrinks SW and RW to W bits.
package spm_pkg;

  localparam logic [1:0] TRIT_ZERO  = 2'b00;
  localparam logic [1:0] TRIT_PLUS  = 2'b01;
  localparam logic [1:0] TRIT_RSVD  = 2'b10;  // treated as zero
  localparam logic [1:0] TRIT_MINUS = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Raw sums need $clog2(n) guard bits so that n additions of a W-bit value
  // never overflow; reduced sums always stay below Q.
  function automatic int sum_width(input int w, input int n);
`ifdef SPM_MOD_REDUCE_EN
    return w;
`else
    return w + $clog2(n);
`endif
  endfunction

  // The raw difference needs one extra bit for the sign.
  function automatic int res_width(input int w, input int n);
`ifdef SPM_MOD_REDUCE_EN
    return w;
`else
    return sum_width(w, n) + 1;
`endif
  endfunction

endpackage

// File: rtl/spm_if.sv
// Beat/handshake bundle for spm_accumulator.
//   slave  modport: the accumulator (drives o_*, samples i_*)
//   master modport: the producer of coefficient beats
// Signals: i_start, i_valid/o_ready handshake, i_coef_a (W), i_coef_r (2),
//          o_sum_one/o_sum_mone (SW), o_result (RW), o_busy, o_done.
// SW/RW follow SPM_MOD_REDUCE_EN through the package helpers.
interface spm_if
  import spm_pkg::*;
#(
  parameter int N  = 16,
  parameter int W  = 8,
  parameter int SW = sum_width(W, N),
  parameter int RW = res_width(W, N)
) ();

  logic          i_start;
  logic          i_valid;
  logic          o_ready;
  logic [W-1:0]  i_coef_a;
  logic [1:0]    i_coef_r;
  logic [SW-1:0] o_sum_one;
  logic [SW-1:0] o_sum_mone;
  logic [RW-1:0] o_result;
  logic          o_busy;
  logic          o_done;

  modport slave (
    input  i_start, i_valid, i_coef_a, i_coef_r,
    output o_ready, o_sum_one, o_sum_mone, o_result, o_busy, o_done
  );

  modport master (
    output i_start, i_valid, i_coef_a, i_coef_r,
    input  o_ready, o_sum_one, o_sum_mone, o_result, o_busy, o_done
  );

endinterface

// File: rtl/spm_modadd.sv
// Combinational modular adder/subtractor.
//   i_a, i_b : operands, both assumed < Q
//   o_sum    : (i_a + i_b) mod Q
//   o_diff   : (i_a - i_b) mod Q, in 0..Q-1
// Each result needs at most one conditional correction because the
// operands are already reduced.
module spm_modadd #(
  parameter int W = 8,
  parameter int Q = 251
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic [W-1:0] o_diff
);

  localparam logic [W:0] QX = (W+1)'(Q);

  logic [W:0] raw_sum;
  logic [W:0] raw_diff;

  always_comb begin
    raw_sum  = {1'b0, i_a} + {1'b0, i_b};
    raw_diff = {1'b0, i_a} - {1'b0, i_b};

    if (raw_sum >= QX) o_sum = W'(raw_sum - QX);
    else               o_sum = raw_sum[W-1:0];

    // a < b: the W+1 bit difference wrapped; adding Q brings it into 0..Q-1.
    if (i_a < i_b) o_diff = W'(raw_diff + QX);
    else           o_diff = raw_diff[W-1:0];
  end

endmodule

// File: rtl/spm_accumulator.sv
// Ternary-secret polynomial accumulator. After i_start it accepts N
// coefficient beats over a valid/ready handshake, summing a_i into
// o_sum_one where r_i = +1 and into o_sum_mone where r_i = -1, then pulses
// o_done for one cycle. Results hold until the next accepted i_start.
// Ports:
//   i_clock, i_reset : clock, synchronous active-high reset
//   bus (spm_if.slave): i_start, i_valid/o_ready, i_coef_a, i_coef_r,
//                       o_sum_one, o_sum_mone, o_result, o_busy, o_done
// Build option: SPM_MOD_REDUCE_EN -> all arithmetic mod Q, W-bit outputs;
// otherwise raw unsigned sums and a two's-complement signed difference.
module spm_accumulator
  import spm_pkg::*;
#(
  parameter int N = 16,
  parameter int W = 8,
  parameter int Q = 251
) (
  input  logic i_clock,
  input  logic i_reset,
  spm_if.slave bus
);

  localparam int SW = sum_width(W, N);
  localparam int RW = res_width(W, N);
  localparam int CW = $clog2(N);

  state_e        state_q,    state_d;
  logic [CW-1:0] cnt_q,      cnt_d;
  logic [SW-1:0] sum_one_q,  sum_one_d;
  logic [SW-1:0] sum_mone_q, sum_mone_d;

  logic          is_plus;
  logic          is_minus;
  logic          last_beat;
  logic [SW-1:0] one_next;
  logic [SW-1:0] mone_next;
  logic [RW-1:0] result;

  assign is_plus   = (bus.i_coef_r == TRIT_PLUS);
  assign is_minus  = (bus.i_coef_r == TRIT_MINUS);
  // Terminal detect on N-1: the counter never has to represent N itself.
  assign last_beat = (cnt_q == CW'(N - 1));

`ifdef SPM_MOD_REDUCE_EN
  logic [W-1:0] acc_sel;
  logic [W-1:0] acc_next;
  logic [W-1:0] acc_diff_unused;
  logic [W-1:0] res_sum_unused;

  // Only one sum changes per beat, so a single reducing adder is shared.
  assign acc_sel = is_plus ? sum_one_q : sum_mone_q;

  spm_modadd #(.W(W), .Q(Q)) u_acc (
    .i_a    (acc_sel),
    .i_b    (bus.i_coef_a),
    .o_sum  (acc_next),
    .o_diff (acc_diff_unused)
  );

  spm_modadd #(.W(W), .Q(Q)) u_res (
    .i_a    (sum_one_q),
    .i_b    (sum_mone_q),
    .o_sum  (res_sum_unused),
    .o_diff (result)
  );

  assign one_next  = acc_next;
  assign mone_next = acc_next;
`else
  assign one_next  = sum_one_q  + SW'(bus.i_coef_a);
  assign mone_next = sum_mone_q + SW'(bus.i_coef_a);
  assign result    = RW'(sum_one_q) - RW'(sum_mone_q);
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    sum_one_d  = sum_one_q;
    sum_mone_d = sum_mone_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_d    = ST_ACCUM;
          cnt_d      = '0;
          sum_one_d  = '0;
          sum_mone_d = '0;
        end
      end
      ST_ACCUM: begin
        if (bus.i_valid) begin
          if (is_plus)  sum_one_d  = one_next;
          if (is_minus) sum_mone_d = mone_next;
          if (last_beat) state_d = ST_DONE;
          else           cnt_d   = cnt_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (i_reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      sum_one_q  <= '0;
      sum_mone_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sum_one_q  <= sum_one_d;
      sum_mone_q <= sum_mone_d;
    end
  end

  assign bus.o_ready    = (state_q == ST_ACCUM);
  assign bus.o_busy     = (state_q == ST_ACCUM);
  assign bus.o_done     = (state_q == ST_DONE);
  assign bus.o_sum_one  = sum_one_q;
  assign bus.o_sum_mone = sum_mone_q;
  // Sums reset to zero, so the derived result is zero out of reset as well.
  assign bus.o_result   = result;

endmodule

// File: tb/tb_spm_accumulator.sv
// Directed self-checking bench for spm_accumulator with N=4, W=8, Q=251.
// Expected values are hand-computed for both builds (SPM_MOD_REDUCE_EN
// defined or not).
module tb_spm_accumulator;
  import spm_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int Q  = 251;
  localparam int SW = sum_width(W, N);
  localparam int RW = res_width(W, N);

`ifdef SPM_MOD_REDUCE_EN
  localparam bit MOD = 1'b1;
`else
  localparam bit MOD = 1'b0;
`endif

  localparam logic [1:0] TP = 2'b01;
  localparam logic [1:0] TM = 2'b11;
  localparam logic [1:0] TZ = 2'b00;
  localparam logic [1:0] TX = 2'b10;

  typedef struct {
    logic [3:0][7:0] a;
    logic [3:0][1:0] r;
    int              one;
    int              mone;
    int              res;
  } vec_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   done_cnt;
  vec_t vecs[6];

  spm_if #(.N(N), .W(W)) bus ();

  spm_accumulator #(.N(N), .W(W), .Q(Q)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (bus.o_done === 1'b1) done_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int a0, a1, a2, a3,
                              input logic [1:0] r0, r1, r2, r3,
                              input int one, mone, res);
    vec_t v;
    v.a[0] = a0[7:0]; v.a[1] = a1[7:0]; v.a[2] = a2[7:0]; v.a[3] = a3[7:0];
    v.r[0] = r0; v.r[1] = r1; v.r[2] = r2; v.r[3] = r3;
    v.one = one; v.mone = mone; v.res = res;
    return v;
  endfunction

  function automatic int res_val(input logic [RW-1:0] x);
    if (MOD) return int'(x);
    else     return int'($signed(x));
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_sums(input string tag, input vec_t v);
    check({tag, " sum_one"},  int'(bus.o_sum_one),  v.one);
    check({tag, " sum_mone"}, int'(bus.o_sum_mone), v.mone);
    check({tag, " result"},   res_val(bus.o_result), v.res);
  endtask

  // One full operation. gap = idle cycles between beats; noise holds i_start
  // high through ACCUM and into DONE, where it must be ignored.
  task automatic run_op(input string tag, input vec_t v, input int gap, input bit noise);
    int d0;
    d0 = done_cnt;
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = noise;
    check({tag, " busy in accum"}, int'(bus.o_busy), 1);
    check({tag, " ready in accum"}, int'(bus.o_ready), 1);
    for (int i = 0; i < N; i++) begin
      bus.i_valid  = 1'b1;
      bus.i_coef_a = v.a[i];
      bus.i_coef_r = v.r[i];
      @(negedge clk);
      if (i < N - 1 && gap > 0) begin
        bus.i_valid  = 1'b0;
        bus.i_coef_a = 8'd77;
        bus.i_coef_r = TP;
        repeat (gap) @(negedge clk);
        check({tag, " no done while stalled"}, int'(bus.o_done), 0);
      end
    end
    bus.i_valid = 1'b0;
    check({tag, " done pulse"}, int'(bus.o_done), 1);
    check({tag, " busy in done"}, int'(bus.o_busy), 0);
    check_sums(tag, v);
    @(negedge clk);
    bus.i_start = 1'b0;
    check({tag, " done single cycle"}, int'(bus.o_done), 0);
    check({tag, " idle after done"}, int'(bus.o_busy), 0);
    check({tag, " done count"}, done_cnt - d0, 1);
    check_sums({tag, " hold"}, v);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    done_cnt = 0;
    rst      = 1'b1;
    bus.i_start  = 1'b0;
    bus.i_valid  = 1'b0;
    bus.i_coef_a = '0;
    bus.i_coef_r = TZ;

    vecs[0] = mk(10, 20, 30, 240, TP, TM, TZ, TP, 250, 20, 230);
    vecs[1] = mk(200, 100, 0, 0, TP, TP, TZ, TZ, MOD ? 49 : 300, 0, MOD ? 49 : 300);
    vecs[2] = mk(5, 0, 0, 0, TM, TZ, TZ, TZ, 0, 5, MOD ? 246 : -5);
    vecs[3] = mk(200, 100, 50, 0, TM, TM, TP, TZ, 50, MOD ? 49 : 300, MOD ? 1 : -250);
    vecs[4] = mk(7, 9, 11, 13, TX, TP, TX, TM, 9, 13, MOD ? 247 : -4);
    vecs[5] = mk(250, 250, 250, 1, TM, TM, TP, TP, MOD ? 0 : 251, MOD ? 249 : 500,
                 MOD ? 2 : -249);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy",   int'(bus.o_busy),   0);
    check("reset ready",  int'(bus.o_ready),  0);
    check("reset done",   int'(bus.o_done),   0);
    check("reset sum_one",  int'(bus.o_sum_one),  0);
    check("reset sum_mone", int'(bus.o_sum_mone), 0);
    check("reset result",   res_val(bus.o_result), 0);
    rst = 1'b0;

    // Beats presented while idle are ignored
    @(negedge clk);
    bus.i_valid  = 1'b1;
    bus.i_coef_a = 8'd100;
    bus.i_coef_r = TP;
    repeat (2) @(negedge clk);
    check("idle ready low", int'(bus.o_ready), 0);
    check("idle beat ignored", int'(bus.o_sum_one), 0);
    bus.i_valid = 1'b0;

    // Table of back-to-back operations
    for (int k = 0; k < 6; k++) run_op($sformatf("vec%0d", k), vecs[k], 0, 1'b0);

    // Valid toggled every other cycle
    run_op("stall", vecs[0], 1, 1'b0);

    // Start held through ACCUM and DONE; reserved trits contribute nothing
    run_op("start_noise", vecs[4], 0, 1'b1);

    // Reset after two beats, then a clean run
    @(negedge clk);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.i_valid  = 1'b1;
      bus.i_coef_a = vecs[0].a[i];
      bus.i_coef_r = vecs[0].r[i];
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    check("partial sum_one", int'(bus.o_sum_one), 10);
    rst = 1'b1;
    begin
      int d0;
      d0 = done_cnt;
      @(negedge clk);
      rst = 1'b0;
      check("abort busy",     int'(bus.o_busy),     0);
      check("abort sum_one",  int'(bus.o_sum_one),  0);
      check("abort sum_mone", int'(bus.o_sum_mone), 0);
      check("abort result",   res_val(bus.o_result), 0);
      repeat (4) @(negedge clk);
      check("abort no done", done_cnt - d0, 0);
    end
    run_op("after_abort", vecs[0], 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spm_accumulator.md
SPM_ACCUMULATOR -- requirements
Module: spm_accumulator

Interface
REQ-001 Parameter N, default 16: coefficients per polynomial, power of two, 4..1024.
REQ-002 Parameter W, default 8: coefficient width.
REQ-003 Parameter Q, default 251: modulus, Q < 2^W.
REQ-004 i_clock  input  1: sole clock, all state updates on rising edge.
REQ-005 i_reset  input  1: synchronous, active-high reset.
REQ-006 i_start  input  1: begin a new accumulation; sampled only when o_busy=0.
REQ-007 i_valid  input  1: coefficient beat valid.
REQ-008 o_ready  output  1: beat accepted on edge where i_valid & o_ready.
REQ-009 i_coef_a  input  W: coefficient of a, caller guarantees value < Q.
REQ-010 i_coef_r  input  2: ternary secret trit; 01=+1, 11=-1, 00=0, 10=0.
REQ-011 o_sum_one  output  SW: accumulated a_i where r_i=+1.
REQ-012 o_sum_mone  output  SW: accumulated a_i where r_i=-1.
REQ-013 o_result  output  RW: sum_one minus sum_mone.
REQ-014 o_busy  output  1: high in ACCUM.
REQ-015 o_done  output  1: one-cycle pulse when all N beats have been accumulated.

Function
REQ-016 FSM states IDLE, ACCUM, DONE.
- IDLE->ACCUM on i_start.
- ACCUM->DONE on acceptance of the Nth beat.
- DONE->IDLE unconditionally next cycle.
REQ-017 Entering ACCUM clears both sums and the beat counter in the same edge.
REQ-018 o_ready = 1 only in ACCUM; beats with i_valid in IDLE/DONE are ignored.
REQ-019 i_valid low in ACCUM stalls; counter and sums hold.
REQ-020 Each accepted beat:
- trit +1 adds i_coef_a to sum_one;
- trit -1 adds to sum_mone;
- 0/10 adds nothing;
- counter increments.
REQ-021 o_done pulses in DONE, one cycle after the edge accepting beat N; o_sum_one, o_sum_mone and o_result are valid in that cycle and hold until the next i_start.
REQ-022 i_start while o_busy=1 is ignored.
REQ-023 i_start in DONE is ignored; i_start in the following IDLE cycle is honoured.
REQ-024 Counter is $clog2(N) bits plus terminal detect; no wrap within an operation.

Reset
REQ-025 On i_reset, regardless of state:
- state=IDLE, counter=0, sums=0, o_result=0;
- o_done=0, o_busy=0, o_ready=0.
REQ-026 Reset mid-ACCUM discards partial sums; no o_done is produced for the aborted run.

Configuration
REQ-027 Macro SPM_MOD_REDUCE_EN defined:
- SW=W, RW=W;
- every add is reduced mod Q, using one conditional subtract;
- o_result = (sum_one - sum_mone) mod Q, in 0..Q-1.
REQ-028 SPM_MOD_REDUCE_EN undefined:
- SW=W+$clog2(N), RW=SW+1;
- sums are raw unsigned and cannot overflow;
- o_result is two's-complement signed difference.

Structure
REQ-029 Package spm_pkg holds:
- trit encoding constants;
- state enum;
- width helper functions for SW/RW.
REQ-030 Sub-module spm_modadd (W, Q): combinational a+b mod Q and a-b mod Q, instantiated only under SPM_MOD_REDUCE_EN.

Verification
REQ-031 With the macro, N=4: a={10,20,30,240}, r={+1,-1,0,+1} -> o_done once, sum_one=250, sum_mone=20, result=230.
REQ-032 With the macro, N=4: a={200,100,0,0}, r={+1,+1,0,0} -> sum_one=49 (300 mod 251); a={5,0,0,0} with r={-1,0,0,0} gives result=246.
REQ-033 Without the macro, N=4: a={200,100,50,0}, r={-1,-1,+1,0} -> sum_one=50, sum_mone=300, result=-250.
REQ-034 i_valid toggled every other cycle during ACCUM -> identical sums to REQ-031; o_done 1 cycle after 4th accept.
REQ-035 i_reset asserted after 2 beats, then fresh start with REQ-031 data -> no spurious o_done; REQ-031 results.
REQ-036 i_start pulsed during ACCUM and in DONE -> ignored; trit 10 beats contribute 0.
